// File: rtl/lcd_pkg.sv
// Shared LCD panel constants, FSM state type and strap-to-ID decode.
// Imported by the init controller and reused by the driver bench.
package lcd_pkg;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  localparam logic [2:0] CODE_4342 = 3'b000;
  localparam logic [2:0] CODE_7084 = 3'b001;
  localparam logic [2:0] CODE_7016 = 3'b010;
  localparam logic [2:0] CODE_4384 = 3'b100;
  localparam logic [2:0] CODE_1018 = 3'b101;
  localparam logic [2:0] CODE_BAD  = 3'b111;

  typedef enum logic [2:0] {
    ST_ISOLATE,
    ST_SAMPLE,
    ST_LATCH,
    ST_HOLD,
    ST_RUN
  } lcd_state_t;

  typedef struct packed {
    logic [15:0] id;
    logic        err;
  } lcd_id_t;

  function automatic lcd_id_t lcd_decode(input logic [2:0] code);
    lcd_id_t r;
    r.id  = 16'h0000;
    r.err = 1'b0;
    case (code)
      CODE_4342: r.id = ID_4342;
      CODE_7084: r.id = ID_7084;
      CODE_7016: r.id = ID_7016;
      CODE_4384: r.id = ID_4384;
      CODE_1018: r.id = ID_1018;
      default:   r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight fade: duty ramps 0..255 while enabled, compared
// against a free-running 8-bit phase; full on at duty 255.
module lcd_bl_pwm #(
  parameter int FADE_STEP_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bl
);

  localparam int SW = $clog2(FADE_STEP_CYC + 1);

  logic [7:0]    p;
  logic [7:0]    duty;
  logic [SW-1:0] step;

  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= '0;
      duty <= '0;
      step <= '0;
      bl   <= 1'b0;
    end else begin
      p <= p + 8'd1;
      if (!en) begin
        duty <= '0;
        step <= '0;
        bl   <= 1'b0;
      end else begin
        bl <= (duty == 8'hff) || (p < duty);
        if (step == SW'(FADE_STEP_CYC - 1)) begin
          step <= '0;
          if (duty != 8'hff)
            duty <= duty + 8'd1;
        end else begin
          step <= step + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lcd_init_ctrl.sv
// Panel power-up sequencer: isolate pins, read ID straps, hold the
// driver in reset, then release it. Fade backlight under LCD_BL_FADE_EN.
module lcd_init_ctrl
  import lcd_pkg::*;
#(
  parameter int SETTLE_CYC    = 1000,
  parameter int STABLE_CNT    = 4,
  parameter int SAMPLE_MAX    = 4096,
  parameter int DRV_HOLD      = 16,
  parameter int FADE_STEP_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  input  logic        reid_req,
  output logic        rgb_oe,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err,
  output logic        drv_rst_n,
  output logic        lcd_bl,
  output logic        busy
);

  localparam int M1   = (SETTLE_CYC > SAMPLE_MAX) ? SETTLE_CYC : SAMPLE_MAX;
  localparam int CMAX = (M1 > DRV_HOLD) ? M1 : DRV_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int MW   = $clog2(STABLE_CNT + 1);

  lcd_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [MW-1:0] match, match_n;
  logic [2:0]    code, prev, code_q, code_n;
  lcd_id_t       dec;
  logic          run_n;

  assign code  = {rgb_in[7], rgb_in[15], rgb_in[23]};
  assign dec   = lcd_decode(code_q);
  assign run_n = (state_n == ST_RUN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    match_n = match;
    code_n  = code_q;
    unique case (state)
      ST_ISOLATE: begin
        match_n = '0;
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          state_n = ST_SAMPLE;
          cnt_n   = '0;
        end
      end
      ST_SAMPLE: begin
        // zero match count marks the first sample: nothing to compare yet
        match_n = (match == '0 || code != prev) ? MW'(1) : match + MW'(1);
        if (match_n == MW'(STABLE_CNT)) begin
          state_n = ST_LATCH;
          code_n  = code;
          cnt_n   = '0;
        end else if (cnt == CW'(SAMPLE_MAX - 1)) begin
          state_n = ST_LATCH;
          code_n  = CODE_BAD;
          cnt_n   = '0;
        end
      end
      ST_LATCH: begin
        state_n = ST_HOLD;
        cnt_n   = '0;
      end
      ST_HOLD: begin
        if (cnt == CW'(DRV_HOLD - 1)) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end
      end
      ST_RUN: begin
        cnt_n = cnt;
        if (reid_req) begin
          state_n = ST_ISOLATE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_ISOLATE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ISOLATE;
      cnt       <= '0;
      match     <= '0;
      prev      <= '0;
      code_q    <= '0;
      rgb_oe    <= 1'b0;
      lcd_id    <= '0;
      id_valid  <= 1'b0;
      id_err    <= 1'b0;
      drv_rst_n <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      match     <= match_n;
      prev      <= code;
      code_q    <= code_n;
      rgb_oe    <= !(state_n inside {ST_ISOLATE, ST_SAMPLE});
      drv_rst_n <= run_n;
      busy      <= !run_n;
      if (state == ST_LATCH) begin
        lcd_id   <= dec.id;
        id_err   <= dec.err;
        id_valid <= 1'b1;
      end else if (state_n == ST_ISOLATE) begin
        id_err   <= 1'b0;
        id_valid <= 1'b0;
      end
    end
  end

`ifdef LCD_BL_FADE_EN
  lcd_bl_pwm #(
    .FADE_STEP_CYC(FADE_STEP_CYC)
  ) u_bl_pwm (
    .clk(clk),
    .rst(rst),
    .en (run_n),
    .bl (lcd_bl)
  );
`else
  always_ff @(posedge clk) begin
    if (rst) lcd_bl <= 1'b0;
    else     lcd_bl <= run_n;
  end
`endif

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Directed bench for lcd_init_ctrl: strap decode, debounce, timeout,
// re-identify and mid-sequence reset, with hand-computed cycle numbers.
module tb_lcd_init_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgb_in;
  logic        reid_req;
  logic        rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;
  logic        drv_rst_n;
  logic        lcd_bl;
  logic        busy;

  lcd_init_ctrl #(
    .SETTLE_CYC   (8),
    .STABLE_CNT   (4),
    .SAMPLE_MAX   (32),
    .DRV_HOLD     (4),
    .FADE_STEP_CYC(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rgb_in   (rgb_in),
    .reid_req (reid_req),
    .rgb_oe   (rgb_oe),
    .lcd_id   (lcd_id),
    .id_valid (id_valid),
    .id_err   (id_err),
    .drv_rst_n(drv_rst_n),
    .lcd_bl   (lcd_bl),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int mode;
  logic [2:0] steady;
  int reid_at;
  int t_oe, t_valid, t_drv;
  int bl_first;
  int bl_from, bl_to, bl_gaps;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int c);
    logic [2:0] r;
    case (mode)
      1:       r = (c >= 18) ? 3'b101 : (c[0] ? 3'b001 : 3'b000);
      2:       r = c[0] ? 3'b001 : 3'b000;
      default: r = steady;
    endcase
    return r;
  endfunction

  function automatic logic [23:0] mk(input logic [2:0] c);
    logic [23:0] noise;
    noise = 24'($urandom) & 24'h7f7f7f;
    return noise | {c[0], 7'b0, c[1], 7'b0, c[2], 7'b0};
  endfunction

  task automatic clr_marks();
    t_oe     = -1;
    t_valid  = -1;
    t_drv    = -1;
    bl_first = -1;
  endtask

  task automatic run(input int stop);
    while (cyc < stop) begin
      rgb_in   = mk(pat(cyc));
      reid_req = (cyc == reid_at);
      if (rgb_oe && t_oe < 0) t_oe = cyc;
      if (id_valid && t_valid < 0) t_valid = cyc;
      if (drv_rst_n && t_drv < 0) begin
        t_drv    = cyc;
        bl_first = int'(lcd_bl);
      end
      if (cyc >= bl_from && cyc < bl_to && !lcd_bl) bl_gaps++;
      @(negedge clk);
      cyc++;
    end
    reid_req = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_oe"},    int'(rgb_oe),    0);
    check({tag, "_id"},    int'(lcd_id),    0);
    check({tag, "_valid"}, int'(id_valid),  0);
    check({tag, "_err"},   int'(id_err),    0);
    check({tag, "_drv"},   int'(drv_rst_n), 0);
    check({tag, "_bl"},    int'(lcd_bl),    0);
    check({tag, "_busy"},  int'(busy),      1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    clr_marks();
  endtask

  task automatic check_seq(input string tag, input int e_oe,
                           input int e_valid, input int e_drv,
                           input int e_id, input int e_err);
    check({tag, "_t_oe"},    t_oe,    e_oe);
    check({tag, "_t_valid"}, t_valid, e_valid);
    check({tag, "_t_drv"},   t_drv,   e_drv);
    check({tag, "_id"},      int'(lcd_id), e_id);
    check({tag, "_err"},     int'(id_err), e_err);
    check({tag, "_busy"},    int'(busy),   0);
`ifdef LCD_BL_FADE_EN
    check({tag, "_bl_first"}, bl_first, 0);
`else
    check({tag, "_bl_first"}, bl_first, 1);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rgb_in   = '0;
    reid_req = 1'b0;
    mode     = 0;
    steady   = 3'b001;
    reid_at  = -1;
    bl_from  = 0;
    bl_to    = 0;
    bl_gaps  = 0;

    // steady 001 from reset, then long RUN for backlight
    reset_dut();
    check_reset("rst0");
    run(30);
    check_seq("c001", 12, 13, 17, 16'h7084, 0);
`ifdef LCD_BL_FADE_EN
    bl_from = 532;
`else
    bl_from = 18;
`endif
    bl_to   = 560;
    bl_gaps = 0;
    run(560);
    check("bl_hold", bl_gaps, 0);
    check("bl_end", int'(lcd_bl), 1);
    bl_to = 0;

    // re-identify from RUN with new code 010
    steady  = 3'b010;
    reid_at = 565;
    run(566);
    check("reid_drv",   int'(drv_rst_n), 0);
    check("reid_valid", int'(id_valid),  0);
    check("reid_bl",    int'(lcd_bl),    0);
    check("reid_oe",    int'(rgb_oe),    0);
    check("reid_busy",  int'(busy),      1);
    reid_at = -1;
    cyc = 0;
    clr_marks();
    run(30);
    check_seq("reid", 12, 13, 17, 16'h7016, 0);

    // toggling 000/001 for 10 sample cycles, then 101; reid in HOLD ignored
    mode    = 1;
    reset_dut();
    reid_at = 24;
    run(40);
    reid_at = -1;
    check_seq("tog", 22, 23, 27, 16'h1018, 0);

    // toggling throughout sampling: timeout forces code 111
    mode = 2;
    reset_dut();
    run(60);
    check_seq("tmo", 40, 41, 45, 16'h0000, 1);

    // unknown steady code 011
    mode   = 0;
    steady = 3'b011;
    reset_dut();
    run(30);
    check_seq("c011", 12, 13, 17, 16'h0000, 1);

    // other decode entries
    steady = 3'b000;
    reset_dut();
    run(30);
    check("c000_id", int'(lcd_id), 16'h4342);
    steady = 3'b100;
    reset_dut();
    run(30);
    check("c100_id", int'(lcd_id), 16'h4384);

    // reset mid-SAMPLE
    steady = 3'b001;
    reset_dut();
    run(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_smp");
    cyc = 0;
    clr_marks();
    run(30);
    check_seq("smp_rst", 12, 13, 17, 16'h7084, 0);

    // reset mid-HOLD
    steady = 3'b101;
    reset_dut();
    run(15);
    check("hold_pre_valid", int'(id_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_hld");
    steady = 3'b001;
    cyc = 0;
    clr_marks();
    run(30);
    check_seq("hld_rst", 12, 13, 17, 16'h7084, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
